// File: rtl/project_switch_ctrl.sv
// Project switch controller: a Wishbone-mapped sequencer that moves the
// harness from one user project to another. Each switch isolates the pads,
// holds every project in reset, releases only the new one, then lets it
// settle before the pads are reconnected.
module project_switch_ctrl #(
  parameter int unsigned NUM_PROJECTS   = 3,
  parameter logic [31:0] ADDR_CTRL      = 32'h00FF00F0,
  parameter logic [31:0] ADDR_STATUS    = 32'h00FF00F4,
  parameter int unsigned QUIESCE_CYCLES = 16,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [7:0]              active_project_o,
  output logic [NUM_PROJECTS-1:0] project_reset_o,
  output logic                    io_gate_o,
  output logic                    busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISOLATE = 3'd1,
    ST_RESET   = 3'd2,
    ST_RELEASE = 3'd3
  } state_e;

  // Phase counters load "length - 1" on entry and leave the phase at zero,
  // so each phase lasts exactly its parameter in clocks and never wraps.
  localparam logic [7:0] QUIESCE_LOAD = 8'(QUIESCE_CYCLES - 1);
  localparam logic [7:0] RESET_LOAD   = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] NUM_P8       = 8'(NUM_PROJECTS);

  // All projects held in reset except the one at index idx.
  function automatic logic [NUM_PROJECTS-1:0] release_mask(input logic [7:0] idx);
    logic [NUM_PROJECTS-1:0] m;
    for (int i = 0; i < NUM_PROJECTS; i++) m[i] = (8'(i) != idx);
    return m;
  endfunction

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              active_q, active_d;
  logic [7:0]              target_q, target_d;
  logic                    err_range_q, err_range_d;
  logic                    err_busy_q, err_busy_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic [NUM_PROJECTS-1:0] proj_rst_q, proj_rst_d;
  logic                    gate_q, gate_d;

  logic        valid, hit_ctrl, hit_status, wr, ctrl_wr, status_wr;
  logic        req_bad, start;
  logic [7:0]  req;
  logic [31:0] status_word, ctrl_word;

  // Bits of the write data and byte selects that carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{wbs_dat_i[31:11], wbs_dat_i[8]};

  // Bus decode and register images seen by a read.
  always_comb begin
    valid       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    hit_ctrl    = (wbs_adr_i == ADDR_CTRL);
    hit_status  = (wbs_adr_i == ADDR_STATUS);
    wr          = valid & wbs_we_i & (wbs_sel_i != 4'b0);
    ctrl_wr     = wr & hit_ctrl & wbs_sel_i[0];
    status_wr   = wr & hit_status;
    req         = wbs_dat_i[7:0];
    req_bad     = (req >= NUM_P8);
    start       = ctrl_wr & ~req_bad & (state_q == ST_IDLE) & (req != active_q);
    status_word = {13'b0, state_q, 5'b0, err_busy_q, err_range_q, gate_q, active_q};
    ctrl_word   = {24'b0, target_q};
  end

  // Next-state, phase counter, error flags and registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    target_d   = target_q;

    ack_d      = valid & (hit_ctrl | hit_status);
    dat_d      = ack_d ? (hit_status ? status_word : ctrl_word) : dat_q;

    // Setting wins over a coincident write-one-to-clear.
    err_range_d = (ctrl_wr & req_bad) |
                  (err_range_q & ~(status_wr & wbs_dat_i[9]));
    err_busy_d  = (ctrl_wr & ~req_bad & (state_q != ST_IDLE)) |
                  (err_busy_q & ~(status_wr & wbs_dat_i[10]));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ISOLATE;
          cnt_d    = QUIESCE_LOAD;
          target_d = req;
        end
      end
      ST_ISOLATE: begin
        if (cnt_q == 8'd0) begin
          state_d  = ST_RESET;
          cnt_d    = RESET_LOAD;
          active_d = target_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESET: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RELEASE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so the
    // harness sees glitch-free resets and pad gating.
    gate_d = (state_d != ST_IDLE);
    if (state_d == ST_RESET)        proj_rst_d = '1;
    else if (state_d == ST_RELEASE) proj_rst_d = release_mask(target_d);
    else                            proj_rst_d = release_mask(active_d);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of statement order.
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      active_q    <= 8'd0;
      target_q    <= 8'd0;
      err_range_q <= 1'b0;
      err_busy_q  <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
      proj_rst_q  <= release_mask(8'd0);
      gate_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      target_q    <= target_d;
      err_range_q <= err_range_d;
      err_busy_q  <= err_busy_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      proj_rst_q  <= proj_rst_d;
      gate_q      <= gate_d;
    end
  end

  assign wbs_ack_o        = ack_q;
  assign wbs_dat_o        = dat_q;
  assign active_project_o = active_q;
  assign project_reset_o  = proj_rst_q;
  assign io_gate_o        = gate_q;
  assign busy_o           = gate_q;

endmodule

// File: tb/tb_project_switch_ctrl.sv
// Bench for project_switch_ctrl: Wishbone driver with a read-data scoreboard
// checked on every ack, plus cycle-level watches of the switch sequence.
module tb_project_switch_ctrl;

  localparam int          NP     = 3;
  localparam logic [31:0] CTRL   = 32'h00FF00F0;
  localparam logic [31:0] STATUS = 32'h00FF00F4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   dat_i, adr;
  logic          ack;
  logic [31:0]   dat_o;
  logic [7:0]    active;
  logic [NP-1:0] proj_rst;
  logic          gate, busy;

  always #5 clk = ~clk;

  project_switch_ctrl #(.NUM_PROJECTS(NP)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .active_project_o(active), .project_reset_o(proj_rst),
    .io_gate_o(gate), .busy_o(busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   ack_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every ack pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ack) begin
      ack_cnt++;
      if (sb_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        if (e.chk) check(e.tag, dat_o, e.data);
      end
    end
  end

  // Drives one transaction; returns one step after the ack edge (or timeout).
  task automatic wb_xfer(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input bit exp_ack, input bit chk, input logic [31:0] exp_rd);
    bit got = 1'b0;
    if (exp_ack) sb_q.push_back('{tag: tag, data: exp_rd, chk: chk});
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({tag, "_ack"}, 32'(got), 32'(exp_ack));
    if (exp_ack && !got) void'(sb_q.pop_back());
  endtask

  // Transaction plus a check that exactly the expected number of acks came.
  task automatic wb_txn(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit exp_ack, input bit chk, input logic [31:0] exp_rd);
    int n0 = ack_cnt;
    wb_xfer(tag, w, a, d, s, exp_ack, chk, exp_rd);
    repeat (2) @(negedge clk);
    check({tag, "_ackcnt"}, 32'(ack_cnt - n0), 32'(exp_ack));
  endtask

  // Follows a switch from the ack edge (k=0) until busy drops.
  task automatic watch_seq(input string tag, input logic [7:0] exp_act,
                           input logic [NP-1:0] rst_iso, input logic [NP-1:0] rst_fin);
    int busy_n = 0, gate_n = 0, act_k = -1;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      busy_n += int'(busy);
      gate_n += int'(gate);
      if (act_k < 0 && active == exp_act) act_k = k;
      if (k == 8)  check({tag, "_rst_isolate"}, 32'(proj_rst), 32'(rst_iso));
      if (k == 20) check({tag, "_rst_reset"},   32'(proj_rst), 32'({NP{1'b1}}));
      @(posedge clk); #1;
    end
    check({tag, "_busy_len"},  32'(busy_n), 32'd36);
    check({tag, "_gate_len"},  32'(gate_n), 32'd36);
    check({tag, "_act_clk"},   32'(act_k),  32'd16);
    check({tag, "_active"},    32'(active), 32'(exp_act));
    check({tag, "_rst_final"}, 32'(proj_rst), 32'(rst_fin));
    check({tag, "_gate_off"},  32'(gate),   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n0, busy_n;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; dat_i = 32'd0; adr = 32'd0;
    #12;
    check("rst_active", 32'(active), 32'd0);
    check("rst_proj",   32'(proj_rst), 32'b110);
    check("rst_gate",   32'(gate), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_ack",    32'(ack), 32'd0);
    check("rst_dat",    dat_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    wb_txn("rd_status0", 1'b0, STATUS, 32'd0, 4'hF, 1'b1, 1'b1, 32'd0);

    // Same-project no-op
    wb_txn("noop_wr0", 1'b1, CTRL, 32'd0, 4'h1, 1'b1, 1'b0, 32'd0);
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      busy_n += int'(busy);
    end
    check("noop_busy", 32'(busy_n), 32'd0);
    check("noop_proj", 32'(proj_rst), 32'b110);

    // Range error and W1C
    wb_txn("range_wr5", 1'b1, CTRL, 32'd5, 4'h1, 1'b1, 1'b0, 32'd0);
    check("range_active", 32'(active), 32'd0);
    check("range_busy",   32'(busy), 32'd0);
    wb_txn("range_status", 1'b0, STATUS, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0200);
    wb_txn("range_clr",    1'b1, STATUS, 32'h200, 4'h3, 1'b1, 1'b0, 32'd0);
    wb_txn("range_after",  1'b0, STATUS, 32'd0, 4'hF, 1'b1, 1'b1, 32'd0);

    // Ctrl write with byte 0 disabled: acked, no effect
    wb_txn("sel0_off", 1'b1, CTRL, 32'd1, 4'h2, 1'b1, 1'b0, 32'd0);
    check("sel0_busy", 32'(busy), 32'd0);

    // Unmapped address
    wb_txn("unmapped", 1'b1, 32'h00FF00FF, 32'd1, 4'h1, 1'b0, 1'b0, 32'd0);
    check("unmapped_busy", 32'(busy), 32'd0);
    wb_txn("unmapped_status", 1'b0, STATUS, 32'd0, 4'hF, 1'b1, 1'b1, 32'd0);

    // Switch 0 -> 1
    n0 = ack_cnt;
    wb_xfer("sw_wr1", 1'b1, CTRL, 32'd1, 4'h1, 1'b1, 1'b0, 32'd0);
    watch_seq("sw", 8'd1, 3'b110, 3'b101);
    check("sw_ackcnt", 32'(ack_cnt - n0), 32'd1);
    wb_txn("sw_rd_ctrl",   1'b0, CTRL,   32'd0, 4'hF, 1'b1, 1'b1, 32'd1);
    wb_txn("sw_rd_status", 1'b0, STATUS, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0000_0001);

    // Busy error: request 2 while in RESET of a 0 -> 1 switch
    do_reset();
    wb_xfer("be_wr1", 1'b1, CTRL, 32'd1, 4'h1, 1'b1, 1'b0, 32'd0);
    repeat (17) @(posedge clk);
    wb_txn("be_wr2",    1'b1, CTRL,   32'd2, 4'h1, 1'b1, 1'b0, 32'd0);
    wb_txn("be_status", 1'b0, STATUS, 32'd0, 4'hF, 1'b1, 1'b1, 32'h0002_0501);
    for (int i = 0; i < 60 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("be_idle",   32'(busy), 32'd0);
    check("be_active", 32'(active), 32'd1);
    check("be_proj",   32'(proj_rst), 32'b101);
    wb_txn("be_status2", 1'b0, STATUS, 32'd0,   4'hF, 1'b1, 1'b1, 32'h0000_0401);
    wb_txn("be_clr",     1'b1, STATUS, 32'h400, 4'h2, 1'b1, 1'b0, 32'd0);
    wb_txn("be_status3", 1'b0, STATUS, 32'd0,   4'hF, 1'b1, 1'b1, 32'h0000_0001);

    // Mid-sequence reset during ISOLATE of a 1 -> 2 switch
    wb_xfer("mr_wr2", 1'b1, CTRL, 32'd2, 4'h1, 1'b1, 1'b0, 32'd0);
    repeat (5) @(posedge clk);
    check("mr_in_isolate", 32'(gate), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_active", 32'(active), 32'd0);
    check("mr_proj",   32'(proj_rst), 32'b110);
    check("mr_gate",   32'(gate), 32'd0);
    check("mr_busy",   32'(busy), 32'd0);
    check("mr_dat",    dat_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      busy_n += int'(busy);
    end
    check("mr_stays_idle", 32'(busy_n), 32'd0);
    wb_txn("mr_rd_ctrl",   1'b0, CTRL,   32'd0, 4'hF, 1'b1, 1'b1, 32'd0);
    wb_txn("mr_rd_status", 1'b0, STATUS, 32'd0, 4'hF, 1'b1, 1'b1, 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/project_switch_ctrl.md
PROJECT_SWITCH_CTRL -- requirements
Module: project_switch_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROJECTS, default 3, number of selectable projects (1..8).
REQ-002 SHALL have parameter ADDR_CTRL, default 32'h00FF00F0, Wishbone address of the switch-request register.
REQ-003 SHALL have parameter ADDR_STATUS, default 32'h00FF00F4, Wishbone address of the status register.
REQ-004 SHALL have parameters QUIESCE_CYCLES (default 16), RESET_CYCLES (default 16) and SETTLE_CYCLES (default 4), phase lengths in clocks, each in the range 1..255.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, inputs, 1 bit each: Wishbone strobe, cycle and write enable.
REQ-008 SHALL have ports wbs_sel_i (input, 4 bits), wbs_dat_i (input, 32 bits) and wbs_adr_i (input, 32 bits): Wishbone byte select, write data and address.
REQ-009 SHALL have ports wbs_ack_o (output, 1 bit) and wbs_dat_o (output, 32 bits): Wishbone acknowledge and read data.
REQ-010 SHALL have port active_project_o, output, 8 bits: the select value driving the harness IO mux.
REQ-011 SHALL have port project_reset_o, output, NUM_PROJECTS bits: active-high reset to each project, one bit per project.
REQ-012 SHALL have port io_gate_o, output, 1 bit: 1 forces the harness to isolate all pads (outputs 0, oeb all-ones).
REQ-013 SHALL have port busy_o, output, 1 bit: high while a switch sequence is in progress.

Function
REQ-014 SHALL define a valid transaction as wbs_cyc_i & wbs_stb_i & ~wbs_ack_o, and a write as valid & wbs_we_i & (wbs_sel_i != 0).
REQ-015 SHALL register wbs_ack_o as a one-cycle pulse in the cycle after a valid transaction to ADDR_CTRL or ADDR_STATUS, giving exactly one ack per transaction.
REQ-016 SHALL never assert wbs_ack_o for any other address.
REQ-017 SHALL return {13'b0, state[2:0], 5'b0, err_busy, err_range, busy, active[7:0]} as read data for ADDR_STATUS (bits 31:19 zero, 18:16 state, 15:11 zero, 10 err_busy, 9 err_range, 8 busy, 7:0 active); state encoding IDLE=0, ISOLATE=1, RESET=2, RELEASE=3.
REQ-018 SHALL return the pending target in bits 7:0 and zeros elsewhere for a read of ADDR_CTRL.
REQ-019 SHALL update wbs_dat_o in the same edge that asserts wbs_ack_o.
REQ-020 SHALL, for a write to ADDR_STATUS, clear err_range where wbs_dat_i[9]=1 and clear err_busy where wbs_dat_i[10]=1 (write-one-to-clear); all other bits are read-only.
REQ-021 SHALL, for a write to ADDR_CTRL with wbs_sel_i[0]=1, accept target=wbs_dat_i[7:0] as follows:
  - target >= NUM_PROJECTS: set err_range, no state change.
  - FSM not IDLE: set err_busy, ignore target.
  - target == active: no-op.
  - otherwise: latch target and go IDLE->ISOLATE at the ack edge.
REQ-022 SHALL still ack a write to ADDR_CTRL with wbs_sel_i[0]=0, with no side effect.
REQ-023 SHALL behave in ISOLATE as: io_gate_o=1, busy_o=1, project_reset_o unchanged; stay QUIESCE_CYCLES clocks, then go to RESET.
REQ-024 SHALL behave in RESET as: project_reset_o all ones; active_project_o takes target at entry to RESET; stay RESET_CYCLES clocks, then go to RELEASE.
REQ-025 SHALL behave in RELEASE as: project_reset_o = all ones except bit[target]=0; io_gate_o=1; stay SETTLE_CYCLES clocks, then go to IDLE.
REQ-026 SHALL behave in IDLE as: io_gate_o=0, busy_o=0, project_reset_o = all ones except bit[active]=0.
REQ-027 SHALL keep busy_o high for exactly QUIESCE_CYCLES+RESET_CYCLES+SETTLE_CYCLES clocks per switch.
REQ-028 SHALL use an 8-bit phase counter that loads on every state entry and never wraps; no counter overflow is possible.
REQ-029 SHALL, when error-setting and W1C clearing of the same bit coincide in one cycle, give setting priority.

Reset
REQ-030 SHALL, while wb_rst_ni=0, asynchronously force: state=IDLE, active_project_o=0, target=0, project_reset_o = all ones except bit0=0, io_gate_o=0, busy_o=0, err bits=0, wbs_ack_o=0, wbs_dat_o=0.
REQ-031 SHALL abort any sequence in progress when reset is asserted mid-sequence, returning all outputs to the REQ-030 values.
REQ-032 SHALL leave the FSM in IDLE after reset release until a new valid switch request arrives.

Verification
REQ-033 SHALL be verified by scenario Switch: write 1 to ADDR_CTRL -> ack after 1 clk; io_gate_o high for 36 clks; active_project_o becomes 1 at clk 17; project_reset_o ends at 3'b101.
REQ-034 SHALL be verified by scenario Range error: write 5 -> acked; active unchanged; status read = 32'h0000_0200; then write 32'h200 to ADDR_STATUS -> status reads 0.
REQ-035 SHALL be verified by scenario Busy error: write 2 while in RESET from a 0->1 switch -> err_busy=1; the sequence completes with active=1.
REQ-036 SHALL be verified by scenario Unmapped address: write to 32'h00FF00FF -> no ack within 10 clks; no state change.
REQ-037 SHALL be verified by scenario Mid-sequence reset: pulse wb_rst_ni low in ISOLATE -> outputs take REQ-030 values immediately (asynchronously); active=0; project_reset_o=3'b110.
REQ-038 SHALL be verified by scenario Same-project no-op: write 0 while active=0 -> single ack; busy_o stays 0; no reset pulse.
